uctl_mem_rd_seq: RTL and testbench

Burst read sequencer for the USB controller's banked packet memory. It sits directly upstream of the bank-select stage. It turns one burst command (start address, word count) into a stream of single-word requests on the request/ack/data-valid handshake that the bank-select stage decodes and fans out to the four banks. It collects returned words in an internal FIFO and presents them in order on a valid/ready output stream. Typical consumers are the endpoint TX packet path and the DMA engine.

---
 rtl/uctl_mem_rd_seq.sv | 132 +++++++++++++
 tb/tb_uctl_mem_rd_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uctl_mem_rd_seq.sv
// Burst read sequencer for the banked packet memory.
// Splits one burst command into single-word requests toward the bank-select
// stage, buffers returned words in a show-ahead FIFO, and streams them out in
// request order. Reads in flight plus buffered words never exceed FIFO_DEPTH,
// so the FIFO cannot overflow.
//
// Handshakes:
//   request side - uctl_req/uctl_addr are held stable until uctl_rdAck; a
//     request transfers in the cycle where uctl_req=1 and uctl_rdAck=1.
//     uctl_dValid returns one word per earlier accepted request, in order.
//   output side  - uctl_outValid/uctl_outData are stable until accepted; a
//     word transfers in the cycle where uctl_outValid=1 and uctl_outReady=1.
module uctl_mem_rd_seq #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  uctl_clk,
    input  logic                  uctl_rst,
    input  logic                  uctl_start,
    input  logic [ADDR_WIDTH-1:0] uctl_startAddr,
    input  logic [LEN_WIDTH-1:0]  uctl_wordCnt,
    output logic                  uctl_busy,
    output logic                  uctl_done,
    output logic                  uctl_seqErr,
    output logic                  uctl_req,
    output logic [ADDR_WIDTH-1:0] uctl_addr,
    input  logic                  uctl_rdAck,
    input  logic                  uctl_dValid,
    input  logic [DATA_WIDTH-1:0] uctl_rdData,
    output logic [DATA_WIDTH-1:0] uctl_outData,
    output logic                  uctl_outValid,
    input  logic                  uctl_outReady,
    output logic [1:0]            uctl_dbgState
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state, state_n;
    logic [LEN_WIDTH-1:0]  req_left, req_left_n;
    logic [LEN_WIDTH-1:0]  rcv_left, rcv_left_n;
    logic [CW-1:0]         inflight, inflight_n;
    logic [CW-1:0]         occ, occ_n;
    logic [CW:0]           credit_sum;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic                  seq_err;
    logic                  accept, req_acc, push, pop, err_now, req_n;

    // Low address bits are don't-care: requests are always word aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, uctl_startAddr[1:0]};

    // Next-state values for the counters, FSM and request line.
    always_comb begin
        accept     = (state == S_IDLE) && uctl_start;
        req_acc    = uctl_req && uctl_rdAck;
        // A return is legal if a read is outstanding, including one acked now.
        push       = uctl_dValid && ((inflight != '0) || req_acc);
        pop        = (occ != '0) && uctl_outReady;
        err_now    = (uctl_dValid && !push) || (uctl_rdAck && !uctl_req);
        inflight_n = inflight + CW'(req_acc) - CW'(push);
        occ_n      = occ + CW'(push) - CW'(pop);
        req_left_n = accept ? uctl_wordCnt : req_left - LEN_WIDTH'(req_acc);
        rcv_left_n = accept ? uctl_wordCnt : rcv_left - LEN_WIDTH'(push);
        credit_sum = {1'b0, inflight_n} + {1'b0, occ_n};

        state_n = state;
        case (state)
            S_IDLE:  if (accept) state_n = (uctl_wordCnt == '0) ? S_DONE : S_REQ;
            S_REQ:   if (req_left_n == '0) state_n = S_DRAIN;
            S_DRAIN: if ((rcv_left_n == '0) && (inflight_n == '0) && (occ_n == '0))
                         state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase

        // Once raised, req stays up until acked: without an ack the credit
        // sum can only fall, so this term cannot drop it early.
        req_n = (state_n == S_REQ) && (req_left_n != '0) &&
                (credit_sum < (CW+1)'(FIFO_DEPTH));
    end

    // Control state, counters, request address and sticky error flag.
    always_ff @(posedge uctl_clk or posedge uctl_rst) begin
        if (uctl_rst) begin
            state    <= S_IDLE;
            uctl_req <= 1'b0;
            uctl_addr <= '0;
            req_left <= '0;
            rcv_left <= '0;
            inflight <= '0;
            occ      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            seq_err  <= 1'b0;
        end else begin
            state    <= state_n;
            uctl_req <= req_n;
            req_left <= req_left_n;
            rcv_left <= rcv_left_n;
            inflight <= inflight_n;
            occ      <= occ_n;
            if (accept)
                uctl_addr <= {uctl_startAddr[ADDR_WIDTH-1:2], 2'b00};
            else if (req_acc)
                uctl_addr <= uctl_addr + ADDR_WIDTH'(4);
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            seq_err <= (accept ? 1'b0 : seq_err) | err_now;
        end
    end

    // FIFO storage; contents are only visible while occupancy is non-zero.
    always_ff @(posedge uctl_clk) begin
        if (push) mem[wr_ptr] <= uctl_rdData;
    end

    assign uctl_outValid = (occ != '0);
    assign uctl_outData  = uctl_outValid ? mem[rd_ptr] : '0;
    assign uctl_busy     = (state == S_REQ) || (state == S_DRAIN);
    assign uctl_done     = (state == S_DONE);
    assign uctl_seqErr   = seq_err;
    assign uctl_dbgState = state;

endmodule

// File: tb/tb_uctl_mem_rd_seq.sv
// Bench for uctl_mem_rd_seq: a behavioural bank responder plus a reference
// model of the expected address stream, output data order, credit limit,
// busy/done/error behaviour, and directed checks of literal timing points.
module tb_uctl_mem_rd_seq;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst, start, rd_ack, d_valid, out_ready;
  logic [31:0] start_addr, rd_data;
  logic [11:0] word_cnt;
  logic        busy, done, seq_err, req, out_valid;
  logic [31:0] addr, out_data;
  logic [1:0]  dbg_state;

  uctl_mem_rd_seq #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(12), .FIFO_DEPTH(DEPTH)) dut (
    .uctl_clk(clk), .uctl_rst(rst), .uctl_start(start), .uctl_startAddr(start_addr),
    .uctl_wordCnt(word_cnt), .uctl_busy(busy), .uctl_done(done), .uctl_seqErr(seq_err),
    .uctl_req(req), .uctl_addr(addr), .uctl_rdAck(rd_ack), .uctl_dValid(d_valid),
    .uctl_rdData(rd_data), .uctl_outData(out_data), .uctl_outValid(out_valid),
    .uctl_outReady(out_ready), .uctl_dbgState(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [31:0] exp_addr_q[$];   // addresses still to be requested
  logic [31:0] exp_q[$];        // words the DUT must be holding, in order
  int          due_q[$];        // return cycle of each acked read
  bit          busy_exp, done_exp, err_exp;
  bit          busy_n, done_n, err_n;
  int          words_left, ret_idx;
  logic [31:0] data_base;
  int          ack_total, out_total, first_ack_cyc, last_ack_cyc;
  int          lat = 2;
  bit          ack_gaps = 1'b0;
  bit          inj_dv = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Model + responder: checks outputs mid-cycle, then drives the bank side.
  always @(negedge clk) begin
    if (rst) begin
      exp_addr_q.delete(); exp_q.delete(); due_q.delete();
      busy_exp = 0; done_exp = 0; err_exp = 0; words_left = 0;
      rd_ack = 0; d_valid = 0; rd_data = '0;
    end else begin
      chk("busy", busy, busy_exp);
      chk("done", done, done_exp);
      chk("seq_err", seq_err, err_exp);
      chk("out_valid", out_valid, 32'(exp_q.size() != 0));
      busy_n = busy_exp; done_n = 1'b0; err_n = err_exp;

      if (req) begin
        if (exp_addr_q.size() == 0) chk("req_unexpected", req, 0);
        else chk("addr", addr, exp_addr_q[0]);
        chk("credit", 32'((due_q.size() + exp_q.size()) < DEPTH), 1);
      end

      if (exp_q.size() != 0) begin
        chk("out_data", out_data, exp_q[0]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          out_total++;
          words_left--;
          if (words_left == 0) begin busy_n = 1'b0; done_n = 1'b1; end
        end
      end

      if (start && !busy_exp && !done_exp) begin
        err_n = 1'b0;
        exp_addr_q.delete();
        for (int i = 0; i < int'(word_cnt); i++)
          exp_addr_q.push_back({start_addr[31:2], 2'b00} + 32'(4 * i));
        words_left = int'(word_cnt);
        ret_idx = 0;
        first_ack_cyc = -1;
        if (word_cnt == 0) done_n = 1'b1; else busy_n = 1'b1;
      end

      if (req && exp_addr_q.size() != 0 && !(ack_gaps && (cyc % 3 == 0))) begin
        rd_ack = 1'b1;
        void'(exp_addr_q.pop_front());
        due_q.push_back(cyc + lat);
        ack_total++;
        if (first_ack_cyc < 0) first_ack_cyc = cyc;
        last_ack_cyc = cyc;
      end else begin
        rd_ack = 1'b0;
      end

      if (due_q.size() != 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        d_valid = 1'b1;
        rd_data = data_base + 32'(ret_idx);
        ret_idx++;
        exp_q.push_back(rd_data);
      end else if (inj_dv) begin
        d_valid = 1'b1;
        rd_data = 32'hDEAD_BEEF;
        err_n = 1'b1;
      end else begin
        d_valid = 1'b0;
        rd_data = '0;
      end

      busy_exp = busy_n; done_exp = done_n; err_exp = err_n;
    end
  end

  // ---------------- driver tasks ----------------
  int c0;

  task automatic start_cmd(input logic [31:0] a, input logic [11:0] n, input logic [31:0] base);
    @(posedge clk); #1;
    data_base = base; start_addr = a; word_cnt = n; start = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic at_cyc(input int t);
    @(negedge clk);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while ((busy_exp || done_exp || exp_q.size() != 0) && n < 400);
    if (n >= 400) fail_now("idle_wait");
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_seq_err"}, seq_err, 0);
    chk({tag, "_req"}, req, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  int a0, o0, n;

  initial begin
    rst = 1'b0; start = 0; start_addr = '0; word_cnt = '0; out_ready = 1'b1;
    rd_ack = 0; d_valid = 0; rd_data = '0; data_base = '0;
    ack_total = 0; out_total = 0; first_ack_cyc = -1; last_ack_cyc = 0;
    #1 rst = 1'b1;
    #2 chk_reset_outputs("por");
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single word
    start_cmd(32'h100, 12'd1, 32'hA5A5_0001);
    at_cyc(c0 + 1);
    chk("single_req", req, 1);
    chk("single_addr", addr, 32'h100);
    chk("single_busy", busy, 1);
    at_cyc(c0 + 4);
    chk("single_out_valid", out_valid, 1);
    chk("single_out_data", out_data, 32'hA5A5_0001);
    at_cyc(c0 + 5);
    chk("single_done", done, 1);
    chk("single_busy_low", busy, 0);
    wait_idle();

    // 8-word burst, ack held, latency 2
    a0 = ack_total; o0 = out_total;
    start_cmd(32'h1000, 12'd8, 32'hB000_0000);
    wait_idle();
    chk("burst8_acks", ack_total - a0, 8);
    chk("burst8_first_ack", first_ack_cyc, c0 + 1);
    chk("burst8_back_to_back", last_ack_cyc - first_ack_cyc, 7);
    chk("burst8_outs", out_total - o0, 8);
    chk("burst8_seq_err", seq_err, 0);

    // Backpressure
    a0 = ack_total; o0 = out_total;
    @(posedge clk); #1 out_ready = 1'b0;
    start_cmd(32'h2000, 12'd8, 32'hC000_0000);
    repeat (12) @(negedge clk);
    chk("bp_acks_stalled", ack_total - a0, 4);
    chk("bp_req_low", req, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_out_head", out_data, 32'hC000_0000);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_idle();
    chk("bp_acks_total", ack_total - a0, 8);
    chk("bp_outs", out_total - o0, 8);

    // Zero count
    a0 = ack_total;
    start_cmd(32'h3000, 12'd0, 32'h0);
    at_cyc(c0 + 1);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_req", req, 0);
    wait_idle();
    chk("zero_no_acks", ack_total - a0, 0);

    // Address wrap
    start_cmd(32'hFFFF_FFF8, 12'd4, 32'hD000_0000);
    at_cyc(c0 + 1); chk("wrap_addr0", addr, 32'hFFFF_FFF8);
    at_cyc(c0 + 2); chk("wrap_addr1", addr, 32'hFFFF_FFFC);
    at_cyc(c0 + 3); chk("wrap_addr2", addr, 32'h0000_0000);
    at_cyc(c0 + 4); chk("wrap_addr3", addr, 32'h0000_0004);
    wait_idle();

    // Ack gaps with same-cycle data return (unaligned start address)
    o0 = out_total;
    @(posedge clk); #1 ack_gaps = 1'b1; lat = 0;
    start_cmd(32'h4013, 12'd6, 32'hE000_0000);
    wait_idle();
    chk("gap_outs", out_total - o0, 6);
    @(posedge clk); #1 ack_gaps = 1'b0; lat = 2;

    // Protocol error: spurious return while idle
    @(posedge clk); #1 inj_dv = 1'b1;
    @(posedge clk); #1 inj_dv = 1'b0;
    @(negedge clk);
    chk("spur_seq_err", seq_err, 1);
    chk("spur_no_out", out_valid, 0);
    start_cmd(32'h5000, 12'd2, 32'hF000_0000);
    at_cyc(c0 + 1);
    chk("spur_cleared", seq_err, 0);
    wait_idle();

    // Reset mid-burst
    a0 = ack_total;
    start_cmd(32'h6000, 12'd8, 32'h1100_0000);
    n = 0;
    while ((ack_total - a0) < 3 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) fail_now("mid_reset_ack_wait");
    @(posedge clk); #3 rst = 1'b1;
    #1 chk_reset_outputs("mid");
    @(negedge clk);
    @(negedge clk); #2 rst = 1'b0;
    o0 = out_total;
    start_cmd(32'h7000, 12'd2, 32'h2200_0000);
    wait_idle();
    chk("post_reset_outs", out_total - o0, 2);
    chk("post_reset_seq_err", seq_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
